// File: rtl/vu_pkg.sv
// Shared types and helpers for the VU-meter window sequencer.
// Holds the sample width, the FSM state encoding, the level payload and saturating byte helpers.
package vu_pkg;

    localparam int unsigned SAMPLE_W = 8;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [SAMPLE_W-1:0] avg;
        logic [SAMPLE_W-1:0] peak;
        logic [SAMPLE_W-1:0] hold;
    } level_t;

    // Magnitude of a signed byte; -128 has no positive twin and clamps to 127.
    function automatic logic [SAMPLE_W-1:0] abs_sat8(input logic signed [SAMPLE_W-1:0] x);
        logic [SAMPLE_W-1:0] u;
        u = $unsigned(x);
        if (u == 8'h80) begin
            return 8'h7F;
        end
        if (u[SAMPLE_W-1]) begin
            return SAMPLE_W'(~u + 8'd1);
        end
        return u;
    endfunction

    function automatic logic [SAMPLE_W-1:0] sat_sub8(input logic [SAMPLE_W-1:0] a,
                                                     input logic [SAMPLE_W-1:0] b);
        return (a > b) ? SAMPLE_W'(a - b) : '0;
    endfunction

endpackage

// File: rtl/vu_abs_acc.sv
// Magnitude datapath for one window scan: sums |byte| and tracks the largest |byte|.
// The sum is one window deep wide (SAMPLE_W + LOG2N bits), so it cannot wrap.
module vu_abs_acc
    import vu_pkg::*;
#(
    parameter int unsigned LOG2N = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        en,
    input  logic signed [SAMPLE_W-1:0]  data,
    output logic [SAMPLE_W+LOG2N-1:0]   sum,
    output logic [SAMPLE_W-1:0]         pk
);

    localparam int unsigned SUM_W = SAMPLE_W + LOG2N;

    logic [SAMPLE_W-1:0] mag;

    assign mag = abs_sat8(data);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sum <= '0;
            pk  <= '0;
        end else if (en) begin
            sum <= SUM_W'(sum + SUM_W'(mag));
            if (mag > pk) begin
                pk <= mag;
            end
        end
    end

endmodule

// File: rtl/vu_window_ctrl.sv
// VU-meter window sequencer: accepts samples, drives the external window shift,
// scans the window after every HOP samples and publishes average, peak and decaying peak-hold.
module vu_window_ctrl
    import vu_pkg::*;
#(
    parameter int unsigned N_SAMPLES = 16,
    parameter int unsigned LOG2N     = 4,
    parameter int unsigned W         = 8 * N_SAMPLES,
    parameter int unsigned HOP       = 16,
    parameter int unsigned DECAY     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    input  logic [SAMPLE_W-1:0]  s_data,
    output logic                 s_ready,
    output logic                 win_shift,
    output logic [SAMPLE_W-1:0]  win_data,
    input  logic [W-1:0]         win_bus,
    output logic [SAMPLE_W-1:0]  level_avg,
    output logic [SAMPLE_W-1:0]  level_peak,
    output logic [SAMPLE_W-1:0]  peak_hold,
    output logic                 level_valid,
    output logic                 busy
);

    localparam int unsigned         SUM_W    = SAMPLE_W + LOG2N;
    localparam logic [LOG2N-1:0]    LAST_IDX = LOG2N'(N_SAMPLES - 1);
    localparam logic [LOG2N-1:0]    HOP_LAST = LOG2N'(HOP - 1);
    localparam logic [SAMPLE_W-1:0] DECAY_B  = SAMPLE_W'(DECAY);

    state_e               state_q;
    state_e               state_d;
    logic [LOG2N-1:0]     samp_cnt;
    logic [LOG2N-1:0]     hop_cnt;
    logic                 primed;
    logic [LOG2N-1:0]     idx;
    logic                 accept;
    logic                 trigger;
    logic                 acc_en;
    logic [SAMPLE_W-1:0]  scan_byte;
    logic [SUM_W-1:0]     sum;
    logic [SAMPLE_W-1:0]  pk;
    logic [SAMPLE_W-1:0]  hold_dec;
    level_t               level_q;

    assign accept   = s_valid && s_ready;
    assign win_data = s_data;

    // The measurement fires on the accept that completes the first full window,
    // then on every HOP-th accept after it.
    assign trigger = accept &&
                     ((primed  && (hop_cnt  == HOP_LAST)) ||
                      (!primed && (samp_cnt == LAST_IDX)));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (trigger) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (idx == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = FILL;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Output decode
    always_comb begin
        s_ready   = 1'b0;
        win_shift = 1'b0;
        busy      = 1'b0;
        acc_en    = 1'b0;
        case (state_q)
            FILL: begin
                s_ready   = !rst;
                win_shift = s_valid && !rst;
            end
            SCAN: begin
                busy   = 1'b1;
                acc_en = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Priming and hop counters
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_cnt <= '0;
            hop_cnt  <= '0;
            primed   <= 1'b0;
        end else if (accept) begin
            if (!primed) begin
                if (samp_cnt == LAST_IDX) begin
                    primed  <= 1'b1;
                    hop_cnt <= '0;
                end else begin
                    samp_cnt <= LOG2N'(samp_cnt + LOG2N'(1));
                end
            end else if (hop_cnt == HOP_LAST) begin
                hop_cnt <= '0;
            end else begin
                hop_cnt <= LOG2N'(hop_cnt + LOG2N'(1));
            end
        end
    end

    // Scan index walks oldest to newest byte while in SCAN
    always_ff @(posedge clk) begin
        if (rst || (state_q != SCAN)) begin
            idx <= '0;
        end else begin
            idx <= LOG2N'(idx + LOG2N'(1));
        end
    end

    assign scan_byte = win_bus[{idx, 3'b000} +: SAMPLE_W];

    vu_abs_acc #(
        .LOG2N (LOG2N)
    ) u_abs_acc (
        .clk  (clk),
        .rst  (rst),
        .clr  (trigger),
        .en   (acc_en),
        .data (scan_byte),
        .sum  (sum),
        .pk   (pk)
    );

    assign hold_dec = sat_sub8(level_q.hold, DECAY_B);

    // Level registers load as DONE exits; level_valid marks the following FILL cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q     <= '0;
            level_valid <= 1'b0;
        end else begin
            level_valid <= (state_q == DONE);
            if (state_q == DONE) begin
                level_q.avg  <= SAMPLE_W'(sum >> LOG2N);
                level_q.peak <= pk;
                level_q.hold <= (pk > hold_dec) ? pk : hold_dec;
            end
        end
    end

    assign level_avg  = level_q.avg;
    assign level_peak = level_q.peak;
    assign peak_hold  = level_q.hold;

endmodule
